// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encodings and NOP word for the pipeline hazard sequencer
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ISTALL = 2'd1,
    ST_DSTALL = 2'd2
  } state_t;

  // sll $0,$0,0: the bubble word the datapath muxes into a flushed register
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/event_counter.sv
// rtl/event_counter.sv - free-running wrap-around event counter with enable
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the five-stage pipeline registers
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             imiss,
  input  logic             iready,
  input  logic             dmiss,
  input  logic             dready,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic             we_if_id,
  output logic             we_id_ex,
  output logic             we_ex_mem,
  output logic             we_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state, state_next;
  logic   drop_fetch, drop_next;
  logic   ipend, pend_now;
  logic   d_stall, br_hit, lu_hit;

  // A data-side stall freezes everything upstream, so it masks every other hazard.
  assign d_stall  = (state == ST_DSTALL) ? !dready : dmiss;
  assign br_hit   = !d_stall && branch_taken;
  assign lu_hit   = !d_stall && !branch_taken && load_use;
  assign pend_now = (ipend || imiss) && !iready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      drop_fetch <= 1'b0;
      ipend      <= 1'b0;
    end else begin
      state      <= state_next;
      drop_fetch <= drop_next;
      ipend      <= pend_now;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop_fetch;
    if (d_stall) begin
      state_next = ST_DSTALL;
    end else begin
      case (state)
        ST_RUN: begin
          if (!branch_taken && !load_use && imiss) state_next = ST_ISTALL;
        end
        ST_ISTALL: begin
          if (iready) begin
            state_next = ST_RUN;
            drop_next  = 1'b0;
          end else if (branch_taken) begin
            drop_next = 1'b1;
          end
        end
        ST_DSTALL: begin
          // Resume the icache wait if its fill is still in flight; a branch here makes it wrong-path.
          state_next = pend_now ? ST_ISTALL : ST_RUN;
          drop_next  = pend_now && (drop_fetch || branch_taken);
        end
        default: begin
          state_next = ST_RUN;
          drop_next  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    pc_redirect  = 1'b0;
    we_if_id     = 1'b1;
    we_id_ex     = 1'b1;
    we_ex_mem    = 1'b1;
    we_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_mem_wb = 1'b0;
    if (!reset) begin
      pc_we        = 1'b0;
      we_if_id     = 1'b0;
      we_id_ex     = 1'b0;
      we_ex_mem    = 1'b0;
      we_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (d_stall) begin
      pc_we        = 1'b0;
      we_if_id     = 1'b0;
      we_id_ex     = 1'b0;
      we_ex_mem    = 1'b0;
      we_mem_wb    = 1'b0;
      flush_mem_wb = 1'b1;
    end else if (br_hit) begin
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (lu_hit) begin
      pc_we       = 1'b0;
      we_if_id    = 1'b0;
      flush_id_ex = 1'b1;
    end else if ((state == ST_ISTALL && !(iready && !drop_fetch)) ||
                 (state == ST_RUN && imiss)) begin
      pc_we       = 1'b0;
      flush_if_id = 1'b1;
    end
  end

  event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (!pc_we),
    .count (stall_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pc_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  localparam logic [5:0] ID = 6'b000000;
  localparam logic [5:0] LU = 6'b100000;
  localparam logic [5:0] BR = 6'b010000;
  localparam logic [5:0] IM = 6'b001000;
  localparam logic [5:0] IR = 6'b000100;
  localparam logic [5:0] DM = 6'b000010;
  localparam logic [5:0] DR = 6'b000001;

  // {pc_we, pc_redirect, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, flush_if_id, flush_id_ex, flush_mem_wb}
  localparam logic [8:0] V_RST  = 9'b0_0_0000_111;
  localparam logic [8:0] V_NORM = 9'b1_0_1111_000;
  localparam logic [8:0] V_LU   = 9'b0_0_0111_010;
  localparam logic [8:0] V_BR   = 9'b1_1_1111_110;
  localparam logic [8:0] V_IW   = 9'b0_0_1111_100;
  localparam logic [8:0] V_DW   = 9'b0_0_0000_001;

  localparam int M_RUN = 0, M_IWAIT = 1, M_DWAIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_use = 1'b0, branch_taken = 1'b0, imiss = 1'b0, iready = 1'b0, dmiss = 1'b0, dready = 1'b0;
  logic pc_we, pc_redirect, we_if_id, we_id_ex, we_ex_mem, we_mem_wb;
  logic flush_if_id, flush_id_ex, flush_mem_wb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .imiss        (imiss),
    .iready       (iready),
    .dmiss        (dmiss),
    .dready       (dready),
    .pc_we        (pc_we),
    .pc_redirect  (pc_redirect),
    .we_if_id     (we_if_id),
    .we_id_ex     (we_id_ex),
    .we_ex_mem    (we_ex_mem),
    .we_mem_wb    (we_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_mem_wb (flush_mem_wb),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_mode = M_RUN;
  bit          m_pend = 1'b0;
  bit          m_drop = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  function automatic logic [8:0] dut_vec();
    return {pc_we, pc_redirect, we_if_id, we_id_ex, we_ex_mem, we_mem_wb,
            flush_if_id, flush_id_ex, flush_mem_wb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_RUN;
    m_pend  = 1'b0;
    m_drop  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One cycle of the pipeline seen stage by stage: who freezes, who bubbles, where the miss waits.
  task automatic model_cycle(output logic [8:0] e);
    bit frozen, fetch_bad, npend;
    bit pcw, red, wif, wid, wex, wwb, fif, fid, fwb;
    int nmode;
    pcw = 1; red = 0; wif = 1; wid = 1; wex = 1; wwb = 1; fif = 0; fid = 0; fwb = 0;
    npend  = (m_pend || imiss) && !iready;
    nmode  = m_mode;
    frozen = (m_mode == M_DWAIT) ? !dready : dmiss;
    if (frozen) begin
      pcw = 0; wif = 0; wid = 0; wex = 0; wwb = 0; fwb = 1;
      nmode = M_DWAIT;
    end else begin
      fetch_bad = (m_mode == M_IWAIT && !(iready && !m_drop)) || (m_mode == M_RUN && imiss);
      if (branch_taken) begin
        red = 1; fif = 1; fid = 1;
        m_flush++;
      end else if (load_use) begin
        pcw = 0; wif = 0; fid = 1;
      end else if (fetch_bad) begin
        pcw = 0; fif = 1;
      end
      if (m_mode == M_RUN) begin
        if (imiss && !branch_taken && !load_use) nmode = M_IWAIT;
      end else if (m_mode == M_IWAIT) begin
        if (iready) begin
          nmode  = M_RUN;
          m_drop = 0;
        end else if (branch_taken) begin
          m_drop = 1;
        end
      end else begin
        nmode  = npend ? M_IWAIT : M_RUN;
        m_drop = npend && (m_drop || branch_taken);
      end
    end
    if (!pcw) m_stall++;
    m_mode = nmode;
    m_pend = npend;
    e = {pcw, red, wif, wid, wex, wwb, fif, fid, fwb};
  endtask

  task automatic step(input logic [5:0] v, input bit pin, input logic [8:0] pv);
    logic [8:0] e;
    {load_use, branch_taken, imiss, iready, dmiss, dready} = v;
    @(negedge clk);
    if (!reset) model_reset();
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    if (!reset) e = V_RST;
    else model_cycle(e);
    check("ctrl", 64'(dut_vec()), 64'(e));
    if (pin) check("ctrl_pin", 64'(dut_vec()), 64'(pv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(ID, 1, V_RST);
    step(ID, 0, 0);
    reset = 1'b1;
    step(ID, 1, V_NORM);
    for (int i = 0; i < 9; i++) step(ID, 0, 0);
    check("idle_stall_cnt", 64'(stall_cnt), 64'd0);

    step(LU, 1, V_LU);
    step(ID, 1, V_NORM);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);

    step(BR, 1, V_BR);
    step(ID, 1, V_NORM);
    check("br_flush_cnt", 64'(flush_cnt), 64'd1);

    // imiss, branch two cycles later, iready three cycles after that
    step(IM, 1, V_IW);
    step(ID, 1, V_IW);
    step(BR, 1, V_BR);
    step(ID, 1, V_IW);
    step(ID, 1, V_IW);
    step(IR, 1, V_IW);
    step(ID, 1, V_NORM);
    check("drop_flush_cnt", 64'(flush_cnt), 64'd2);
    check("drop_stall_cnt", 64'(stall_cnt), 64'd6);

    // dcache miss held 4 cycles over a pending icache fill
    step(IM, 1, V_IW);
    for (int i = 0; i < 4; i++) step(DM, 1, V_DW);
    step(DR, 1, V_NORM);
    step(ID, 1, V_IW);
    step(IR, 1, V_NORM);
    step(ID, 1, V_NORM);
    check("dmiss_stall_cnt", 64'(stall_cnt), 64'd12);

    // iready and branch together: branch wins, back to RUN
    step(IM, 0, 0);
    step(BR | IR, 1, V_BR);
    step(ID, 1, V_NORM);

    // load_use holds IF/ID while the icache waits
    step(IM, 0, 0);
    step(LU, 1, V_LU);
    step(IR, 1, V_NORM);
    step(ID, 1, V_NORM);

    // dready coinciding with a branch, no icache fill pending
    step(DM, 1, V_DW);
    step(DR | BR, 1, V_BR);
    step(ID, 1, V_NORM);
    check("mix_flush_cnt", 64'(flush_cnt), 64'd4);
    check("mix_stall_cnt", 64'(stall_cnt), 64'd16);

    // stray ready pulses are ignored
    step(IR, 1, V_NORM);
    step(DR, 1, V_NORM);

    // asynchronous reset in the middle of a dcache stall
    step(IM, 0, 0);
    step(DM, 0, 0);
    step(DM, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ctrl", 64'(dut_vec()), 64'(V_RST));
    check("async_rst_stall", 64'(stall_cnt), 64'd0);
    check("async_rst_flush", 64'(flush_cnt), 64'd0);
    model_reset();
    step(DM, 1, V_RST);
    reset = 1'b1;
    step(DR, 1, V_NORM);
    step(ID, 1, V_NORM);
    step(LU, 1, V_LU);
    step(ID, 0, 0);
    check("post_rst_stall", 64'(stall_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
